// File: rtl/inst_rom_loader_pkg.sv
// Shared constants for the instruction ROM / program loader.
package inst_rom_loader_pkg;

  // Instruction bus word and its all-zero value returned on any inactive fetch.
  typedef logic [31:0] inst_t;
  localparam inst_t ZeroWord = 32'h0000_0000;

  // Level of ce_i that enables a fetch.
  localparam logic ChipEnable = 1'b1;

  // Loader FSM encodings (kept as plain constants so legacy tools can share them).
  localparam logic [1:0] LdIdle = 2'b00;
  localparam logic [1:0] LdLoad = 2'b01;
  localparam logic [1:0] LdDone = 2'b10;

endpackage

// File: rtl/inst_rom_loader.sv
// Instruction memory with a combinational fetch port and a byte-serial, big-endian program
// loader. While a load is running busy_o is high and fetches return zero.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned AW        = 10,
  parameter string       INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce_i,
  input  logic [31:0]   addr_i,
  output logic [31:0]   inst_o,
  input  logic          ld_start_i,
  input  logic [AW:0]   ld_len_i,
  input  logic [7:0]    ld_byte_i,
  input  logic          ld_valid_i,
  output logic          ld_ready_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW-1:0] WordOne = {{(AW - 1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LenOne  = {{AW{1'b0}}, 1'b1};

  logic [31:0]   r_mem [Depth];
  logic [1:0]    r_state;
  logic [AW-1:0] r_word_cnt;
  logic [1:0]    r_byte_cnt;
  logic [23:0]   r_shift;
  logic [AW:0]   r_len;
  logic          r_zero_done;
  logic          r_err;

  logic          w_hs;
  logic          w_word_hs;
  logic          w_last_word;
  logic          w_len_too_big;
  logic          w_mem_we;
  logic [1:0]    w_unused_addr;

  assign ld_ready_o    = (r_state == LdLoad);
  assign busy_o        = (r_state == LdLoad);
  assign done_o        = (r_state == LdDone) | r_zero_done;
  assign err_o         = r_err;

  assign w_hs          = ld_valid_i & ld_ready_o;
  assign w_word_hs     = w_hs & (r_byte_cnt == 2'd3);
  assign w_last_word   = ({1'b0, r_word_cnt} == (r_len - LenOne));
  // Anything above 2**AW: top bit set with any lower bit also set.
  assign w_len_too_big = ld_len_i[AW] & (|ld_len_i[AW-1:0]);
  // A reset coinciding with the fourth byte drops that word.
  assign w_mem_we      = w_word_hs & ~rst;

  // Byte offset within the word is irrelevant to a word-wide fetch.
  assign w_unused_addr = addr_i[1:0];

  // Loader FSM, byte packer and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LdIdle;
      r_word_cnt  <= '0;
      r_byte_cnt  <= '0;
      r_shift     <= '0;
      r_len       <= '0;
      r_zero_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_zero_done <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        LdIdle: begin
          if (ld_start_i) begin
            if (ld_len_i == '0) begin
              r_zero_done <= 1'b1;
            end else if (w_len_too_big) begin
              r_err <= 1'b1;
            end else begin
              r_len      <= ld_len_i;
              r_word_cnt <= '0;
              r_byte_cnt <= '0;
              r_state    <= LdLoad;
            end
          end
        end
        LdLoad: begin
          if (w_hs) begin
            r_shift    <= {r_shift[15:0], ld_byte_i};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_word_hs) begin
              r_word_cnt <= r_word_cnt + WordOne;
              if (w_last_word) r_state <= LdDone;
            end
          end
        end
        LdDone:  r_state <= LdIdle;
        default: r_state <= LdIdle;
      endcase
    end
  end

  // Completed words are written on the edge of their fourth byte; no reset on the array.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_word_cnt] <= {r_shift, ld_byte_i};
  end

  // Combinational fetch: zero unless enabled, idle, out of reset and in range.
  always_comb begin
    inst_o = ZeroWord;
    if (!rst && (ce_i == ChipEnable) && !busy_o && (addr_i[31:AW+2] == '0)) begin
      inst_o = r_mem[addr_i[AW+1:2]];
    end
  end

endmodule
